// File: rtl/lane_sequencer.sv
// lane_sequencer: time-multiplexes one ELEM_W-bit vector lane across the
// NUM_ELEM elements of a vector op. It latches a request, issues one element
// per cycle to the lane, assembles the lane results and presents the vector
// on a valid/ready handshake.
//
// Build option: LANE_SEQ_BACK2BACK_EN lets a new request be accepted in the
// same cycle the finished result is handed off, skipping the IDLE cycle.
//
// state | meaning
// IDLE  | waiting for a request, req_ready high
// ISSUE | driving element cnt_q to the lane and capturing its result
// DONE  | res_vec complete, holding res_valid until res_ready
module lane_sequencer #(
    parameter int ELEM_W   = 16,
    parameter int NUM_ELEM = 4,
    localparam int CNT_W   = $clog2(NUM_ELEM),
    localparam int VEC_W   = ELEM_W * NUM_ELEM
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic              req_size,
    input  logic [VEC_W-1:0]  req_vec,
    input  logic [CNT_W-1:0]  req_idx,
    input  logic [ELEM_W-1:0] req_srcb,
    output logic [2:0]        lane_ctrl,
    output logic [CNT_W-1:0]  lane_id,
    output logic [ELEM_W-1:0] lane_v,
    output logic [CNT_W-1:0]  lane_idx,
    output logic [ELEM_W-1:0] lane_srcb,
    input  logic [ELEM_W-1:0] lane_res,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [VEC_W-1:0]  res_vec,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         op_q, op_d;
    logic               size_q, size_d;
    logic [VEC_W-1:0]   vec_q, vec_d;
    logic [CNT_W-1:0]   idx_q, idx_d;
    logic [ELEM_W-1:0]  srcb_q, srcb_d;
    logic [VEC_W-1:0]   res_q, res_d;
    logic               load;

    // Next-state, handshake outputs and result capture.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        size_d    = size_q;
        vec_d     = vec_q;
        idx_d     = idx_q;
        srcb_d    = srcb_q;
        res_d     = res_q;
        req_ready = 1'b0;
        res_valid = 1'b0;
        load      = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    load    = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                for (int k = 0; k < NUM_ELEM; k++) begin
                    if (cnt_q == CNT_W'(k)) begin
                        res_d[k*ELEM_W +: ELEM_W] = lane_res;
                    end
                end
                if (cnt_q == CNT_W'(NUM_ELEM - 1)) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                res_valid = 1'b1;
`ifdef LANE_SEQ_BACK2BACK_EN
                req_ready = res_ready;
                if (res_ready) begin
                    if (req_valid) begin
                        load    = 1'b1;
                        state_d = ISSUE;
                    end else begin
                        state_d = IDLE;
                    end
                end
`else
                req_ready = 1'b0;
                if (res_ready) begin
                    state_d = IDLE;
                end
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (load) begin
            op_d   = req_op;
            size_d = req_size;
            vec_d  = req_vec;
            idx_d  = req_idx;
            srcb_d = req_srcb;
            cnt_d  = '0;
        end
    end

    // State and operand registers; reset also discards any partial result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            size_q  <= 1'b0;
            vec_q   <= '0;
            idx_q   <= '0;
            srcb_q  <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            size_q  <= size_d;
            vec_q   <= vec_d;
            idx_q   <= idx_d;
            srcb_q  <= srcb_d;
            res_q   <= res_d;
        end
    end

    // Element select: the lane only ever sees latched operands.
    always_comb begin
        lane_v = '0;
        for (int k = 0; k < NUM_ELEM; k++) begin
            if (cnt_q == CNT_W'(k)) begin
                lane_v = vec_q[k*ELEM_W +: ELEM_W];
            end
        end
    end

    assign lane_ctrl = {op_q, size_q};
    assign lane_id   = cnt_q;
    assign lane_idx  = idx_q;
    assign lane_srcb = srcb_q;
    assign res_vec   = res_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_lane_sequencer.sv
// Bench for lane_sequencer: a behavioural lane stub answers each issued
// element, and a per-request model computes the expected assembled vector.
module tb_lane_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic        req_size;
    logic [63:0] req_vec;
    logic [1:0]  req_idx;
    logic [15:0] req_srcb;
    logic [2:0]  lane_ctrl;
    logic [1:0]  lane_id;
    logic [15:0] lane_v;
    logic [1:0]  lane_idx;
    logic [15:0] lane_srcb;
    logic [15:0] lane_res;
    logic        res_valid;
    logic        res_ready;
    logic [63:0] res_vec;
    logic        busy;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

`ifdef LANE_SEQ_BACK2BACK_EN
    localparam int EXP_GAP = 5;
`else
    localparam int EXP_GAP = 6;
`endif

    lane_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_size  (req_size),
        .req_vec   (req_vec),
        .req_idx   (req_idx),
        .req_srcb  (req_srcb),
        .lane_ctrl (lane_ctrl),
        .lane_id   (lane_id),
        .lane_v    (lane_v),
        .lane_idx  (lane_idx),
        .lane_srcb (lane_srcb),
        .lane_res  (lane_res),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_vec   (res_vec),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural lane: norm inverts when size set, ls shifts, inc bumps the
    // target element only, mods takes the remainder by the scalar.
    function automatic logic [15:0] lane_fn(input logic [1:0] op, input logic sz,
                                            input logic [15:0] v, input logic [1:0] id,
                                            input logic [1:0] idx, input logic [15:0] srcb);
        case (op)
            2'b00:   return v ^ {16{sz}};
            2'b01:   return v << srcb[3:0];
            2'b10:   return (id == idx) ? v + 16'd1 : v;
            default: return (srcb == 16'd0) ? v : v % srcb;
        endcase
    endfunction

    function automatic logic [63:0] model_vec(input logic [1:0] op, input logic sz,
                                              input logic [63:0] vec, input logic [1:0] idx,
                                              input logic [15:0] srcb);
        logic [63:0] r;
        r = '0;
        for (int k = 0; k < 4; k++) begin
            r[k*16 +: 16] = lane_fn(op, sz, vec[k*16 +: 16], 2'(k), idx, srcb);
        end
        return r;
    endfunction

    always_comb lane_res = lane_fn(lane_ctrl[2:1], lane_ctrl[0], lane_v, lane_id, lane_idx, lane_srcb);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic garbage_req();
        req_valid = 1'($urandom);
        req_op    = 2'($urandom);
        req_size  = 1'($urandom);
        req_vec   = {$urandom, $urandom};
        req_idx   = 2'($urandom);
        req_srcb  = 16'($urandom);
    endtask

    // One request from IDLE to handoff, checking every issue and hold cycle.
    task automatic run_vector(input string name, input logic [1:0] op, input logic sz,
                              input logic [63:0] vec, input logic [1:0] idx,
                              input logic [15:0] srcb, input int hold);
        logic [63:0] exp;
        exp = model_vec(op, sz, vec, idx, srcb);
        vectors++;
        if (req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL %s idle_ready: got %b want 1", name, req_ready);
        end
        req_valid = 1'b1; req_op = op; req_size = sz; req_vec = vec;
        req_idx = idx; req_srcb = srcb; res_ready = 1'b0;
        step();
        for (int k = 0; k < 4; k++) begin
            garbage_req();
            res_ready = 1'($urandom);
            vectors++;
            if (lane_id !== 2'(k) || lane_v !== vec[k*16 +: 16] || lane_ctrl !== {op, sz} ||
                lane_idx !== idx || lane_srcb !== srcb) begin
                miscompares++;
                $display("FAIL %s issue%0d lane: got id=%0d v=%h ctrl=%b idx=%0d srcb=%h want id=%0d v=%h ctrl=%b idx=%0d srcb=%h",
                         name, k, lane_id, lane_v, lane_ctrl, lane_idx, lane_srcb,
                         k, vec[k*16 +: 16], {op, sz}, idx, srcb);
            end
            vectors++;
            if (res_valid !== 1'b0 || req_ready !== 1'b0 || busy !== 1'b1) begin
                miscompares++;
                $display("FAIL %s issue%0d flags: got valid=%b ready=%b busy=%b want 0 0 1",
                         name, k, res_valid, req_ready, busy);
            end
            step();
        end
        res_ready = 1'b0;
        vectors++;
        if (res_valid !== 1'b1 || res_vec !== exp) begin
            miscompares++;
            $display("FAIL %s result: got valid=%b vec=%h want 1 %h", name, res_valid, res_vec, exp);
        end
        for (int h = 0; h < hold; h++) begin
            garbage_req();
            step();
            vectors++;
            if (res_valid !== 1'b1 || res_vec !== exp || req_ready !== 1'b0 || busy !== 1'b1) begin
                miscompares++;
                $display("FAIL %s hold%0d: got valid=%b vec=%h ready=%b busy=%b want 1 %h 0 1",
                         name, h, res_valid, res_vec, req_ready, busy, exp);
            end
        end
        req_valid = 1'b0;
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        vectors++;
        if (res_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL %s handoff: got valid=%b busy=%b ready=%b want 0 0 1",
                     name, res_valid, busy, req_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b1; res_ready = 1'b0;
        req_op = 2'b11; req_size = 1'b1; req_vec = 64'hFFFF_FFFF_FFFF_FFFF;
        req_idx = 2'd3; req_srcb = 16'hFFFF;
        step();
        step();
        vectors++;
        if (req_ready !== 1'b1 || res_valid !== 1'b0 || busy !== 1'b0 || res_vec !== 64'd0) begin
            miscompares++;
            $display("FAIL reset_flags: got ready=%b valid=%b busy=%b vec=%h want 1 0 0 0",
                     req_ready, res_valid, busy, res_vec);
        end
        vectors++;
        if (lane_ctrl !== 3'd0 || lane_id !== 2'd0 || lane_v !== 16'd0 ||
            lane_idx !== 2'd0 || lane_srcb !== 16'd0) begin
            miscompares++;
            $display("FAIL reset_lane: got ctrl=%b id=%0d v=%h idx=%0d srcb=%h want all zero",
                     lane_ctrl, lane_id, lane_v, lane_idx, lane_srcb);
        end
        rst = 1'b0; req_valid = 1'b0;
        step();
        vectors++;
        if (busy !== 1'b0 || req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_release: got busy=%b ready=%b want 0 1", busy, req_ready);
        end
    endtask

    task automatic test_mods();
        vectors++;
        if (model_vec(2'b11, 1'b0, 64'h0004_0003_0002_0001, 2'd0, 16'd2) !== 64'h0000_0001_0000_0001) begin
            miscompares++;
            $display("FAIL mods_model: reference model disagrees with hand value");
        end
        run_vector("mods", 2'b11, 1'b0, 64'h0004_0003_0002_0001, 2'd0, 16'd2, 0);
    endtask

    task automatic test_inc();
        run_vector("inc", 2'b10, 1'b0, 64'h0010_0010_0010_0010, 2'd2, 16'h1234, 0);
    endtask

    task automatic test_backpressure();
        run_vector("backpressure", 2'b01, 1'b0, 64'h8001_0F0F_1234_00FF, 2'd1, 16'd4, 10);
    endtask

    task automatic test_reset_mid_issue();
        req_valid = 1'b1; req_op = 2'b00; req_size = 1'b1;
        req_vec = 64'h1111_2222_3333_4444; req_idx = 2'd1; req_srcb = 16'd7;
        res_ready = 1'b0;
        step();
        req_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        vectors++;
        if (busy !== 1'b0 || req_ready !== 1'b1 || res_vec !== 64'd0 || lane_id !== 2'd0) begin
            miscompares++;
            $display("FAIL reset_mid: got busy=%b ready=%b vec=%h id=%0d want 0 1 0 0",
                     busy, req_ready, res_vec, lane_id);
        end
        for (int i = 0; i < 6; i++) begin
            step();
            vectors++;
            if (res_valid !== 1'b0 || res_vec !== 64'd0) begin
                miscompares++;
                $display("FAIL reset_mid_quiet%0d: got valid=%b vec=%h want 0 0", i, res_valid, res_vec);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] got_q[$];
        logic [63:0] exp_a, exp_b;
        int acc_cyc[2];
        int n_acc;
        n_acc = 0;
        exp_a = model_vec(2'b01, 1'b0, 64'h0001_0002_0003_0004, 2'd0, 16'd3);
        exp_b = model_vec(2'b10, 1'b1, 64'hAAAA_5555_0000_FFFF, 2'd3, 16'd9);
        req_valid = 1'b1; req_op = 2'b01; req_size = 1'b0;
        req_vec = 64'h0001_0002_0003_0004; req_idx = 2'd0; req_srcb = 16'd3;
        res_ready = 1'b1;
        for (int c = 0; c < 40 && got_q.size() < 2; c++) begin
            logic acc;
            acc = req_valid && req_ready;
            if (res_valid && res_ready) got_q.push_back(res_vec);
            step();
            if (acc) begin
                acc_cyc[n_acc] = cyc;
                n_acc++;
                if (n_acc == 1) begin
                    req_op = 2'b10; req_size = 1'b1;
                    req_vec = 64'hAAAA_5555_0000_FFFF; req_idx = 2'd3; req_srcb = 16'd9;
                end else begin
                    req_valid = 1'b0;
                end
            end
        end
        req_valid = 1'b0;
        res_ready = 1'b0;
        vectors++;
        if (n_acc != 2 || got_q.size() != 2) begin
            miscompares++;
            $display("FAIL b2b_count: got accepts=%0d results=%0d want 2 2", n_acc, got_q.size());
        end else begin
            vectors++;
            if (acc_cyc[1] - acc_cyc[0] != EXP_GAP) begin
                miscompares++;
                $display("FAIL b2b_gap: got %0d want %0d", acc_cyc[1] - acc_cyc[0], EXP_GAP);
            end
            vectors++;
            if (got_q[0] !== exp_a || got_q[1] !== exp_b) begin
                miscompares++;
                $display("FAIL b2b_results: got %h %h want %h %h", got_q[0], got_q[1], exp_a, exp_b);
            end
        end
        step();
    endtask

    task automatic test_random();
        for (int i = 0; i < 20; i++) begin
            run_vector("random", 2'($urandom), 1'($urandom), {$urandom, $urandom},
                       2'($urandom), 16'($urandom_range(0, 40)), int'($urandom_range(0, 3)));
        end
    endtask

    initial begin
        test_reset();
        test_mods();
        test_inc();
        test_backpressure();
        test_reset_mid_issue();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
